// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low hex patterns, capture FSM states, anode idle value.
// Reused by both the segment encoder side and the scan-capture monitor.
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Index of the (lowest) active-low anode; only meaningful when exactly one is low
    function automatic logic [1:0] an_index(input logic [3:0] an_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!an_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-low segment pattern to hex nibble decoder.
// Zero latency; o_vld low (nibble 0) for patterns outside the hex table.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nib,
    output logic       o_vld
);

    always_comb begin
        o_nib = 4'h0;
        o_vld = 1'b1;
        case (i_seg)
            SEG_0: o_nib = 4'h0;
            SEG_1: o_nib = 4'h1;
            SEG_2: o_nib = 4'h2;
            SEG_3: o_nib = 4'h3;
            SEG_4: o_nib = 4'h4;
            SEG_5: o_nib = 4'h5;
            SEG_6: o_nib = 4'h6;
            SEG_7: o_nib = 4'h7;
            SEG_8: o_nib = 4'h8;
            SEG_9: o_nib = 4'h9;
            SEG_A: o_nib = 4'hA;
            SEG_B: o_nib = 4'hB;
            SEG_C: o_nib = 4'hC;
            SEG_D: o_nib = 4'hD;
            SEG_E: o_nib = 4'hE;
            SEG_F: o_nib = 4'hF;
            default: o_vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed 4-digit active-low scan bus and rebuilds the shown 16-bit value.
// Inputs registered once; a digit is captured after SETTLE stable cycles; no backpressure.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int IDLE_TO = 64
) (
    input  logic        clk16,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        clr_err,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_mask,
    output logic        seg_err,
    output logic        multi_err,
    output logic        idle
);

    localparam int SCW = $clog2(SETTLE) + 1;
    localparam int ICW = $clog2(IDLE_TO) + 1;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_an, r_lat_an, r_mask;
    logic [6:0]      r_seg, r_lat_pat;
    logic [1:0]      r_lat_idx;
    logic [SCW-1:0]  r_set_cnt;
    logic [ICW-1:0]  r_idle_cnt;
    logic [15:0]     r_shadow, r_value;
    logic            r_fv, r_seg_err, r_multi_err, r_idle;

    logic            w_single, w_multi, w_match;
    logic            w_latch, w_capture, w_set_inc;
    logic [3:0]      w_nib;
    logic            w_dec_vld;

    assign w_single = ($countones(~r_an) == 1);
    assign w_multi  = ($countones(~r_an) > 1);
    assign w_match  = (r_an == r_lat_an) && (r_seg == r_lat_pat);

    seg7_to_hex u_dec (
        .i_seg (r_lat_pat),
        .o_nib (w_nib),
        .o_vld (w_dec_vld)
    );

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            r_an  <= AN_OFF;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= an;
            r_seg <= seg;
        end
    end

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) r_state <= ST_BLANK;
        else        r_state <= w_state_nxt;
    end

    // A multi-anode cycle overrides every state and suppresses capture
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_set_inc   = 1'b0;
        if (w_multi) begin
            w_state_nxt = ST_BLANK;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (w_single) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!w_match) begin
                        w_state_nxt = ST_BLANK;
                    end else if (int'(r_set_cnt) + 1 >= SETTLE - 1) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_set_inc   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_an != r_lat_an) w_state_nxt = ST_BLANK;
                end
                default: w_state_nxt = ST_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            r_lat_an  <= AN_OFF;
            r_lat_pat <= 7'h7F;
            r_lat_idx <= 2'd0;
            r_set_cnt <= '0;
        end else if (w_latch) begin
            r_lat_an  <= r_an;
            r_lat_pat <= r_seg;
            r_lat_idx <= an_index(r_an);
            r_set_cnt <= '0;
        end else if (w_set_inc && (r_set_cnt != SCW'(SETTLE - 1))) begin
            r_set_cnt <= r_set_cnt + 1'b1;
        end
    end

    // Frame completion and a new capture may share a cycle; the capture's mask bit survives
    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
            r_mask   <= '0;
            r_value  <= '0;
            r_fv     <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            if (r_mask == 4'hF) begin
                r_value <= r_shadow;
                r_fv    <= 1'b1;
                r_mask  <= '0;
            end
            if (w_capture) begin
                r_shadow[{r_lat_idx, 2'b00} +: 4] <= w_dec_vld ? w_nib : 4'h0;
                r_mask[r_lat_idx]                 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            r_seg_err   <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            if (w_capture && !w_dec_vld) r_seg_err <= 1'b1;
            else if (clr_err)            r_seg_err <= 1'b0;
            if (w_multi)                 r_multi_err <= 1'b1;
            else if (clr_err)            r_multi_err <= 1'b0;
        end
    end

    // idle holds high out of reset until the first capture
    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
            r_idle     <= 1'b1;
        end else if (w_capture) begin
            r_idle_cnt <= '0;
            r_idle     <= 1'b0;
        end else if (r_idle_cnt != ICW'(IDLE_TO)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
            if (r_idle_cnt == ICW'(IDLE_TO - 1)) r_idle <= 1'b1;
        end
    end

    assign value       = r_value;
    assign frame_valid = r_fv;
    assign digit_mask  = r_mask;
    assign seg_err     = r_seg_err;
    assign multi_err   = r_multi_err;
    assign idle        = r_idle;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scanner-like frames, glitches, errors, idle and reset.
module tb_seg7_scan_capture;

    logic        clk16 = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        clr_err;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  digit_mask;
    logic        seg_err, multi_err, idle;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_count = 0;

    logic [6:0] segt [16];

    always #5 clk16 = ~clk16;

    seg7_scan_capture #(.SETTLE(2), .IDLE_TO(64)) dut (
        .clk16       (clk16),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .clr_err     (clr_err),
        .value       (value),
        .frame_valid (frame_valid),
        .digit_mask  (digit_mask),
        .seg_err     (seg_err),
        .multi_err   (multi_err),
        .idle        (idle)
    );

    always @(negedge clk16) if (frame_valid) fv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk16);
        #1;
    endtask

    task automatic show_digit(input int idx, input logic [6:0] pat, input int hold, input int blank);
        logic [3:0] a;
        a = 4'hF;
        a[idx] = 1'b0;
        an  = a;
        seg = pat;
        repeat (hold) tick();
        an  = 4'hF;
        seg = 7'h7F;
        repeat (blank) tick();
    endtask

    task automatic show_frame(input logic [6:0] p3, input logic [6:0] p2,
                              input logic [6:0] p1, input logic [6:0] p0);
        show_digit(3, p3, 4, 12);
        show_digit(2, p2, 4, 12);
        show_digit(1, p1, 4, 12);
        show_digit(0, p0, 4, 12);
    endtask

    initial begin
        logic prev_idle;
        segt = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        reset   = 1'b0;
        an      = 4'hF;
        seg     = 7'h7F;
        clr_err = 1'b0;
        repeat (3) tick();
        check("rst_value", value, 16'h0);
        check("rst_fv", frame_valid, 0);
        check("rst_mask", digit_mask, 0);
        check("rst_seg_err", seg_err, 0);
        check("rst_multi_err", multi_err, 0);
        check("rst_idle", idle, 1);
        reset = 1'b1;
        repeat (2) tick();

        // Normal scanner frame 1,2,3,4
        show_frame(segt[1], segt[2], segt[3], segt[4]);
        check("f1234_value", value, 16'h1234);
        check("f1234_pulses", fv_count, 1);
        check("f1234_seg_err", seg_err, 0);
        check("f1234_multi_err", multi_err, 0);
        check("f1234_mask", digit_mask, 0);

        // Single-cycle anode glitch must not capture
        show_digit(0, segt[8], 1, 8);
        check("glitch_mask", digit_mask, 0);
        show_frame(segt[10], segt[11], segt[12], segt[13]);
        check("fABCD_value", value, 16'hABCD);
        check("fABCD_pulses", fv_count, 2);

        // Blank pattern in digit 2 decodes as an error, nibble 0
        show_frame(segt[5], 7'h7F, segt[5], segt[5]);
        check("f5055_value", value, 16'h5055);
        check("f5055_seg_err", seg_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        check("clr_seg_err", seg_err, 0);

        // Two anodes low mid-frame
        show_digit(3, segt[9], 4, 12);
        show_digit(2, segt[8], 4, 12);
        an = 4'b0011;
        seg = segt[7];
        tick();
        an = 4'hF;
        seg = 7'h7F;
        repeat (4) tick();
        check("multi_err_set", multi_err, 1);
        check("multi_mask", digit_mask, 4'b1100);
        show_digit(1, segt[7], 4, 12);
        show_digit(0, segt[6], 4, 12);
        check("f9876_value", value, 16'h9876);
        check("f9876_pulses", fv_count, 4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        check("clr_multi_err", multi_err, 0);

        // Idle after a long quiet period, then deassert on the next capture
        repeat (70) tick();
        check("idle_set", idle, 1);
        an = 4'b1110;
        seg = segt[0];
        prev_idle = idle;
        for (int i = 0; i < 10; i++) begin
            if (digit_mask[0]) break;
            prev_idle = idle;
            tick();
        end
        check("idle_cap_mask", digit_mask, 4'b0001);
        check("idle_before_cap", prev_idle, 1);
        check("idle_after_cap", idle, 0);
        tick();
        an = 4'hF;
        seg = 7'h7F;
        repeat (12) tick();
        show_digit(3, segt[3], 4, 12);
        check("pre_rst_mask", digit_mask, 4'b1001);

        // Asynchronous reset mid-frame
        reset = 1'b0;
        #2;
        check("arst_value", value, 16'h0);
        check("arst_mask", digit_mask, 0);
        check("arst_idle", idle, 1);
        check("arst_fv", frame_valid, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        show_digit(3, segt[14], 4, 12);
        show_digit(2, segt[15], 4, 12);
        show_digit(1, segt[0], 4, 12);
        check("post_rst_partial", value, 16'h0);
        show_digit(0, segt[1], 4, 12);
        check("fEF01_value", value, 16'hEF01);
        check("fEF01_pulses", fv_count, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Listens to the multiplexed 4-digit seven-segment scan bus (active-low anodes and segments) that the display scanner drives.
- Rebuilds the displayed 16-bit hex value and flags malformed scan activity.
- Sits beside the display path as an on-chip monitor and self-check for the scanner, mux and segment encoder chain.

Parameters:
- SETTLE, 2, consecutive clk16 cycles a single anode and its segment pattern must stay stable before the pattern is sampled.
- IDLE_TO, 64, clk16 cycles without any digit capture before idle asserts.

Ports:
- clk16  in  1  system clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset.
- an  in  4  anode enables from the scanner, active-low; an[3] is the leftmost digit.
- seg  in  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- clr_err  in  1  synchronous clear of the sticky error flags.
- value  out  16  last complete frame, {d3,d2,d1,d0}.
- frame_valid  out  1  one-cycle pulse when value updates.
- digit_mask  out  4  digits captured so far in the current frame.
- seg_err  out  1  sticky: a sampled pattern is not in the hex table.
- multi_err  out  1  sticky: more than one anode is low in the same cycle.
- idle  out  1  high when no capture has happened for IDLE_TO cycles.

Behaviour:
- Reset (reset=0, asynchronous): value=0, frame_valid=0, digit_mask=0, seg_err=0, multi_err=0, idle=1, FSM=BLANK, settle counter and idle counter = 0, shadow digits = 0.
- Input registering: an and seg are registered once. All decisions use the registered copies, so there is 1 cycle of input latency.
- FSM BLANK:
  - Wait for exactly one anode low (one-hot-low).
  - On that event, latch the anode index and pattern, clear the settle counter, and go to SETTLE.
  - If an==4'b1111, stay in BLANK.
- FSM SETTLE:
  - Each cycle, check that the anode and pattern match the latched values. If they match, increment the counter. If they differ, return to BLANK without capturing.
  - When the counter reaches SETTLE-1 with a match, capture and go to HOLD.
- Capture:
  - Decode the pattern to a nibble, write it to shadow[index] and set digit_mask[index].
  - If the pattern is not in the table: set seg_err, write nibble 0, and still set the mask bit.
- FSM HOLD:
  - Stay while the same anode remains low.
  - Return to BLANK when the anode releases or changes. A direct change to another single anode goes to BLANK and re-enters SETTLE on the next cycle.
  - One capture per anode assertion.
- Frame completion:
  - The cycle after digit_mask becomes 4'b1111: value <= shadow, frame_valid=1 for one cycle, digit_mask <= 0.
  - Capture order is irrelevant. If a digit is captured twice before the frame completes, the latest capture wins.
- multi_err:
  - Set in any state on any cycle where the registered an has two or more zeros.
  - The FSM goes to BLANK, and no capture happens that cycle.
- clr_err=1 clears seg_err and multi_err. If an error event occurs in the same cycle, the set wins.
- Idle counter:
  - Cleared on every capture. Otherwise it increments, saturating at IDLE_TO.
  - idle=1 while the counter equals IDLE_TO.
  - idle deasserts the cycle after a capture.
- Decode table (seg -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->b
  - 1000110->C, 0100001->d, 0000110->E, 0001110->F
- Widths: the settle counter is clog2(SETTLE)+1 bits and the idle counter is clog2(IDLE_TO)+1 bits. Both saturate and never wrap.
- Reset mid-frame discards the shadow and mask contents. The first frame after reset therefore requires four fresh captures.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 active-low segment pattern constants (SEG_0..SEG_F);
  - the FSM state encoding (BLANK, SETTLE, HOLD);
  - the anode all-off constant 4'b1111.
  The encoder side reuses these constants.
- One sub-module: seg7_to_hex, a combinational pattern-to-nibble decoder with a valid output. The top holds all sequential logic.

Test Plan:
- Scanner-like sequence (an3, an2, an1, an0 each low 4 cycles, blanked 12 cycles between) showing 1,2,3,4 -> single frame_valid pulse, value=16'h1234, no errors.
- Anode low for only 1 cycle (SETTLE=2) showing 8 -> no capture, digit_mask unchanged, then a normal frame of A,b,C,d -> value=16'hABCD.
- Digit with seg=7'b1111111 in a frame of 5,_,5,5 -> seg_err=1, value=16'h5055; clr_err pulse -> seg_err=0.
- an=4'b0011 for 1 cycle mid-frame -> multi_err=1, no capture that cycle; a subsequent full frame still completes.
- No anode activity for 64 cycles -> idle=1; next capture -> idle=0 one cycle later.
- Reset asserted after 2 digits captured -> outputs return to reset values immediately; 4 new digits E,F,0,1 are needed -> value=16'hEF01.
